core_exu_result: RTL and testbench
==================================

CORE_EXU_RESULT -- requirements
Module: core_exu_result

Interface
REQ-001 Parameter FWD_EN, default 1: when 1 the fwd_* outputs are live; when 0 they SHALL be tied to 0.
REQ-002 clk  input  1  single core clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  EXU beat valid this cycle.
REQ-005 in_ready  output  1  block can accept a beat.
REQ-006 in_rd_addr  input  5  destination register index.
REQ-007 in_rd_wen  input  1  instruction writes rd.
REQ-008 in_pc  input  32  PC of the instruction.
REQ-009 logic_enable / logic_data_out  input  1 / 32  logic-unit result pair.
REQ-010 arith_enable / arith_data_out  input  1 / 32  arithmetic-unit result pair.
REQ-011 shift_enable / shift_data_out  input  1 / 32  shift-unit result pair.
REQ-012 flush  input  1  discard all buffered and incoming beats.
REQ-013 out_valid  output  1  writeback beat valid.
REQ-014 out_ready  input  1  writeback stage accepts the beat.
REQ-015 out_rd_addr / out_rd_wen / out_rd_data / out_pc  output  5 / 1 / 32 / 32  head-entry fields.
REQ-016 err_multi_hot  output  1  sticky flag: more than one unit enable was seen on an accepted beat.
REQ-017 fwd_valid / fwd_rd_addr / fwd_rd_data  output  1 / 5 / 32  bypass of the head entry to the operand stage.

Function
REQ-018 Result select SHALL be priority-based: logic, then arith, then shift; if no enable is set, selected data = 32'd0.
REQ-019 A beat is accepted when in_valid && in_ready && !flush.
- Accepted beat stores {rd_addr, rd_wen', sel_data, pc}.
- rd_wen' = in_rd_wen && (in_rd_addr != 0).
REQ-020 Storage SHALL be a 2-entry FIFO.
- count in 0..2; in_ready = (count != 2), computed from registered state only.
- in_ready SHALL NOT depend on out_ready.
REQ-021 Latency SHALL be exactly one cycle.
- Beat accepted at edge N into an empty FIFO: out_valid=1 and its fields on out_* from edge N through the cycle it is popped.
REQ-022 out_valid = (count != 0); out_* SHALL show the head entry; pop on out_valid && out_ready.
REQ-023 Simultaneous events:
- Push and pop in the same cycle with count=1: count stays 1; the new beat becomes head.
- Push and pop with count=2: cannot occur, since in_ready=0.
- Pop at count=0: ignored.
REQ-024 While out_valid && !out_ready, out_* SHALL hold stable.
REQ-025 Flush:
- At the next edge count=0 and out_valid=0.
- The beat presented in the flush cycle is dropped.
- err_multi_hot is unaffected.
REQ-026 err_multi_hot SHALL be set at the edge accepting a beat with two or more enables high, and stays set until reset.
REQ-027 With FWD_EN=1, fwd_valid = out_valid && out_rd_wen; fwd_rd_addr = out_rd_addr; fwd_rd_data = out_rd_data. This path is combinational from the registers.
REQ-028 Pointers SHALL wrap modulo 2; full/empty SHALL be derived from count, not from pointer equality.

Reset
REQ-029 With rst=1 at a clock edge: count=0, pointers=0, out_valid=0, out_rd_addr=0, out_rd_wen=0, out_rd_data=0, out_pc=0, err_multi_hot=0, fwd_valid=0.
REQ-030 Reset SHALL dominate flush and push; a beat presented with rst=1 is lost.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Single beat: logic_enable=1, data=32'hA5A5_0F0F, rd=5, wen=1, out_ready=1 -> the next cycle shows out_valid=1, out_rd_data=32'hA5A5_0F0F, fwd_valid=1, fwd_rd_addr=5.
REQ-033 Backpressure: out_ready=0, push 3 beats back-to-back -> in_ready=0 after the 2nd; the 3rd is held upstream; releasing out_ready drains in order with no loss.
REQ-034 rd=0: arith_enable=1, wen=1 -> out_rd_wen=0, fwd_valid=0.
REQ-035 Multi-hot: logic_enable=arith_enable=1, logic=32'h1, arith=32'h2 -> out_rd_data=32'h1; err_multi_hot=1 persists through a flush; rst clears it.
REQ-036 Flush with count=2 plus an incoming beat -> next cycle out_valid=0, in_ready=1; no stale beat ever appears.
REQ-037 Reset mid-stream: rst asserted with count=1 and out_ready=0 -> next cycle all outputs 0, per REQ-029.

Source files
------------

// File: rtl/core_exu_result_if.sv
// EXU-to-writeback beat bus: upstream result beat with ready/valid, downstream head-entry view.
interface core_exu_result_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rd_addr;
  logic              in_rd_wen;
  logic [31:0]       in_pc;
  logic              logic_enable;
  logic [DATA_W-1:0] logic_data_out;
  logic              arith_enable;
  logic [DATA_W-1:0] arith_data_out;
  logic              shift_enable;
  logic [DATA_W-1:0] shift_data_out;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_rd_addr;
  logic              out_rd_wen;
  logic [DATA_W-1:0] out_rd_data;
  logic [31:0]       out_pc;

  modport master (
    output in_valid, in_rd_addr, in_rd_wen, in_pc,
    output logic_enable, logic_data_out, arith_enable, arith_data_out,
    output shift_enable, shift_data_out, out_ready,
    input  in_ready, out_valid, out_rd_addr, out_rd_wen, out_rd_data, out_pc
  );

  modport slave (
    input  in_valid, in_rd_addr, in_rd_wen, in_pc,
    input  logic_enable, logic_data_out, arith_enable, arith_data_out,
    input  shift_enable, shift_data_out, out_ready,
    output in_ready, out_valid, out_rd_addr, out_rd_wen, out_rd_data, out_pc
  );
endinterface

// File: rtl/core_exu_result.sv
// EXU result collector: priority-selects the unit result and buffers beats in a 2-entry FIFO
// ahead of writeback, with a combinational bypass of the head entry.
module core_exu_result #(
  parameter bit FWD_EN = 1'b1,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  core_exu_result_if.slave   exu,
  input  logic               flush,
  output logic               err_multi_hot,
  output logic               fwd_valid,
  output logic [4:0]         fwd_rd_addr,
  output logic [DATA_W-1:0]  fwd_rd_data
);

  typedef struct packed {
    logic [4:0]        rd_addr;
    logic              rd_wen;
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
  } entry_t;

  function automatic logic [DATA_W-1:0] select_result(
    input logic le, input logic ae, input logic se,
    input logic [DATA_W-1:0] ld, input logic [DATA_W-1:0] ad, input logic [DATA_W-1:0] sd
  );
    if (le)      return ld;
    else if (ae) return ad;
    else if (se) return sd;
    else         return '0;
  endfunction

  function automatic logic is_multi_hot(input logic le, input logic ae, input logic se);
    return (le & ae) | (le & se) | (ae & se);
  endfunction

  logic [1:0] count_p1;
  logic       wr_ptr_p1;
  logic       rd_ptr_p1;
  entry_t     mem_p1 [2];
  entry_t     head;
  logic       occupied;
  logic       push;
  logic       pop;

  assign occupied     = (count_p1 != 2'd0);
  assign exu.in_ready = (count_p1 != 2'd2);
  assign push         = exu.in_valid && exu.in_ready && !flush;
  assign pop          = occupied && exu.out_ready;

  // Stage p0 -> p1: accept beat into FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1      <= 2'd0;
      wr_ptr_p1     <= 1'b0;
      rd_ptr_p1     <= 1'b0;
      err_multi_hot <= 1'b0;
    end else begin
      if (push && is_multi_hot(exu.logic_enable, exu.arith_enable, exu.shift_enable))
        err_multi_hot <= 1'b1;
      if (flush) begin
        count_p1  <= 2'd0;
        wr_ptr_p1 <= 1'b0;
        rd_ptr_p1 <= 1'b0;
      end else begin
        if (push) wr_ptr_p1 <= !wr_ptr_p1;
        if (pop)  rd_ptr_p1 <= !rd_ptr_p1;
        case ({push, pop})
          2'b10:   count_p1 <= count_p1 + 2'd1;
          2'b01:   count_p1 <= count_p1 - 2'd1;
          default: count_p1 <= count_p1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_p1[wr_ptr_p1] <= '{
        rd_addr: exu.in_rd_addr,
        rd_wen:  exu.in_rd_wen && (exu.in_rd_addr != 5'd0),
        data:    select_result(exu.logic_enable, exu.arith_enable, exu.shift_enable,
                               exu.logic_data_out, exu.arith_data_out, exu.shift_data_out),
        pc:      exu.in_pc
      };
    end
  end

  // Stage p1 -> writeback: head entry, zeroed while empty so reset leaves outputs at 0
  assign head            = occupied ? mem_p1[rd_ptr_p1] : '0;
  assign exu.out_valid   = occupied;
  assign exu.out_rd_addr = head.rd_addr;
  assign exu.out_rd_wen  = head.rd_wen;
  assign exu.out_rd_data = head.data;
  assign exu.out_pc      = head.pc;

  if (FWD_EN) begin : g_fwd
    assign fwd_valid   = occupied && head.rd_wen;
    assign fwd_rd_addr = head.rd_addr;
    assign fwd_rd_data = head.data;
  end else begin : g_no_fwd
    assign fwd_valid   = 1'b0;
    assign fwd_rd_addr = 5'd0;
    assign fwd_rd_data = '0;
  end

endmodule

// File: tb/tb_core_exu_result.sv
// Bench for core_exu_result: directed vector table, hand sequences and a queue-based random model.
module tb_core_exu_result;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic err_multi_hot;
  logic fwd_valid;
  logic [4:0]  fwd_rd_addr;
  logic [31:0] fwd_rd_data;

  always #5 clk = ~clk;

  core_exu_result_if #(.DATA_W(32)) bus ();

  core_exu_result dut (
    .clk           (clk),
    .rst           (rst),
    .exu           (bus),
    .flush         (flush),
    .err_multi_hot (err_multi_hot),
    .fwd_valid     (fwd_valid),
    .fwd_rd_addr   (fwd_rd_addr),
    .fwd_rd_data   (fwd_rd_data)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] data;
    logic [31:0] pc;
  } ref_t;

  ref_t q[$];
  logic ref_err = 1'b0;

  typedef struct {
    logic        le, ae, se;
    logic [31:0] ld, ad, sd;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] pc;
    logic [31:0] exp_data;
    logic        exp_wen;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive_beat(input logic le, input logic ae, input logic se,
                            input logic [31:0] ld, input logic [31:0] ad, input logic [31:0] sd,
                            input logic [4:0] rd, input logic wen, input logic [31:0] pc);
    bus.in_valid       = 1'b1;
    bus.logic_enable   = le;
    bus.arith_enable   = ae;
    bus.shift_enable   = se;
    bus.logic_data_out = ld;
    bus.arith_data_out = ad;
    bus.shift_data_out = sd;
    bus.in_rd_addr     = rd;
    bus.in_rd_wen      = wen;
    bus.in_pc          = pc;
  endtask

  task automatic compare_model(input string tag);
    logic ev;
    ev = (q.size() != 0);
    check({tag, "_ctl"},
          {bus.out_valid, bus.in_ready, err_multi_hot, fwd_valid},
          {ev, q.size() < 2, ref_err, ev && q[0].wen});
    if (ev)
      check({tag, "_head"},
            {bus.out_rd_addr, bus.out_rd_wen, bus.out_rd_data, bus.out_pc, fwd_rd_addr, fwd_rd_data},
            {q[0].rd, q[0].wen, q[0].data, q[0].pc, q[0].rd, q[0].data});
  endtask

  // Reference behaviour at a rising edge, from the current (pre-edge) inputs and model state.
  task automatic model_edge();
    ref_t e;
    logic acc;
    int   hot;
    if (rst) begin
      q.delete();
      ref_err = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = bus.in_valid && (q.size() < 2);
      if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
      if (acc) begin
        if (bus.logic_enable)      e.data = bus.logic_data_out;
        else if (bus.arith_enable) e.data = bus.arith_data_out;
        else if (bus.shift_enable) e.data = bus.shift_data_out;
        else                       e.data = 32'd0;
        e.rd  = bus.in_rd_addr;
        e.wen = bus.in_rd_wen && (bus.in_rd_addr != 0);
        e.pc  = bus.in_pc;
        q.push_back(e);
        hot = int'(bus.logic_enable) + int'(bus.arith_enable) + int'(bus.shift_enable);
        if (hot >= 2) ref_err = 1'b1;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    compare_model(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag,
          {bus.out_valid, bus.out_rd_addr, bus.out_rd_wen, bus.out_rd_data, bus.out_pc,
           err_multi_hot, fwd_valid, fwd_rd_addr, fwd_rd_data, bus.in_ready},
          {1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1});
  endtask

  initial begin
    tbl[0] = '{1,0,0, 32'hA5A5_0F0F, 32'h0, 32'h0,         5'd5,  1, 32'h100, 32'hA5A5_0F0F, 1, 0};
    tbl[1] = '{0,1,0, 32'h0, 32'h1234_5678, 32'h0,         5'd0,  1, 32'h104, 32'h1234_5678, 0, 0};
    tbl[2] = '{0,0,1, 32'h0, 32'h0, 32'hDEAD_BEEF,         5'd31, 1, 32'h108, 32'hDEAD_BEEF, 1, 0};
    tbl[3] = '{0,0,0, 32'hFFFF_FFFF, 32'h1, 32'h2,         5'd7,  1, 32'h10C, 32'h0,         1, 0};
    tbl[4] = '{0,1,0, 32'h0, 32'h0BAD_F00D, 32'h0,         5'd9,  0, 32'h110, 32'h0BAD_F00D, 0, 0};
    tbl[5] = '{1,1,0, 32'h1, 32'h2, 32'h0,                 5'd3,  1, 32'h114, 32'h1,         1, 1};
    tbl[6] = '{0,1,1, 32'h0, 32'hAAAA, 32'hBBBB,           5'd4,  1, 32'h118, 32'hAAAA,      1, 1};
    tbl[7] = '{1,0,1, 32'h7777, 32'h0, 32'h8888,           5'd6,  1, 32'h11C, 32'h7777,      1, 1};

    rst = 1'b1; flush = 1'b0; bus.out_ready = 1'b0;
    drive_beat(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset_state");

    // Directed vectors: each beat shows up on out_* one cycle after acceptance.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_beat(tbl[i].le, tbl[i].ae, tbl[i].se, tbl[i].ld, tbl[i].ad, tbl[i].sd,
                 tbl[i].rd, tbl[i].wen, tbl[i].pc);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {bus.out_valid, bus.out_rd_addr, bus.out_rd_wen, bus.out_rd_data, bus.out_pc,
             fwd_valid, fwd_rd_addr, fwd_rd_data, err_multi_hot},
            {1'b1, tbl[i].rd, tbl[i].exp_wen, tbl[i].exp_data, tbl[i].pc,
             tbl[i].exp_wen, tbl[i].rd, tbl[i].exp_data, tbl[i].exp_err});
      @(posedge clk);
      #1;
    end

    // Sticky error survives flush, cleared only by reset.
    q.delete();
    ref_err = tbl[7].exp_err;
    flush = 1'b1;
    tick("mh_flush");
    flush = 1'b0;
    check("mh_sticky", err_multi_hot, 1'b1);
    rst = 1'b1;
    tick("mh_rst");
    rst = 1'b0;
    check("mh_cleared", err_multi_hot, 1'b0);

    // Backpressure: third beat waits upstream, then everything drains in order.
    bus.out_ready = 1'b0;
    drive_beat(0, 1, 0, 0, 32'h0000_00B0, 0, 5'd10, 1, 32'h200);
    tick("bp0");
    drive_beat(0, 1, 0, 0, 32'h0000_00B1, 0, 5'd11, 1, 32'h204);
    tick("bp1");
    drive_beat(0, 1, 0, 0, 32'h0000_00B2, 0, 5'd12, 1, 32'h208);
    check("bp_full", bus.in_ready, 1'b0);
    tick("bp_hold0");
    tick("bp_hold1");
    bus.out_ready = 1'b1;
    tick("bp_pop0");
    tick("bp_push2");
    bus.in_valid = 1'b0;
    repeat (3) tick("bp_drain");

    // Flush with FIFO full plus an incoming beat.
    bus.out_ready = 1'b0;
    drive_beat(0, 0, 1, 0, 0, 32'h0000_0F01, 5'd13, 1, 32'h300);
    tick("fl_fill0");
    drive_beat(0, 0, 1, 0, 0, 32'h0000_0F02, 5'd14, 1, 32'h304);
    tick("fl_fill1");
    drive_beat(0, 0, 1, 0, 0, 32'h0000_0F03, 5'd15, 1, 32'h308);
    flush = 1'b1;
    tick("fl_flush");
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_empty", {bus.out_valid, bus.in_ready}, 2'b01);
    bus.out_ready = 1'b1;
    repeat (3) tick("fl_after");

    // Reset mid-stream with one entry held; the beat presented under reset is lost.
    bus.out_ready = 1'b0;
    drive_beat(1, 0, 0, 32'h0000_0C0C, 0, 0, 5'd20, 1, 32'h400);
    tick("rm_push");
    drive_beat(1, 0, 0, 32'h0000_0D0D, 0, 0, 5'd21, 1, 32'h404);
    rst = 1'b1;
    tick("rm_rst");
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_all_zero("rm_zero");
    tick("rm_after");

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive_beat($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), $urandom_range(0, 1), $urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      rst           = ($urandom_range(0, 79) == 0);
      tick("rnd");
    end
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    tick("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
